// File: rtl/uart_cfg_regfile_mc.sv
// Multi-channel UART config register file: N_CH banks of CTRL/BAUD/STATUS/IRQ_EN.
// Optional CTRL[15] lock per channel enabled by defining UART_RF_LOCK_EN.
module uart_cfg_regfile_mc #(
  parameter int DATA_WIDTH = 16,
  parameter int N_CH = 2,
  parameter int READ_LATENCY = 0,
  parameter logic [DATA_WIDTH-1:0] BAUD_DEFAULT = 16'h2580,
  localparam int AW = $clog2(4*N_CH)+1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [AW-1:0]              wr_addr,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  output logic                       wr_err,
  input  logic                       rd_en,
  input  logic [AW-1:0]              rd_addr,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       rd_valid,
  input  logic [N_CH-1:0]            uart_busy,
  input  logic [N_CH-1:0]            uart_error,
  input  logic [N_CH-1:0]            update_ok,
  output logic [N_CH-1:0]            uart_enable,
  output logic [3*N_CH-1:0]          uart_mode,
  output logic [DATA_WIDTH*N_CH-1:0] uart_rate,
  output logic [N_CH-1:0]            irq
);

  localparam logic [AW-1:0] NREG = AW'(4*N_CH);
  localparam int CW = AW-2;

  logic [DATA_WIDTH-1:0] ctrl [N_CH];
  logic [DATA_WIDTH-1:0] act  [N_CH];
  logic [DATA_WIDTH-1:0] shd  [N_CH];
  logic [N_CH-1:0] busy_q, err, pend, ien, irq_q;
  logic [N_CH-1:0] wsel, rsel, lock;
  logic [1:0] wreg, rreg;
  logic wr_inb, rd_inb, wr_rej;
  logic [DATA_WIDTH-1:0] rval;

  assign wreg   = wr_addr[1:0];
  assign rreg   = rd_addr[1:0];
  assign wr_inb = wr_en && (wr_addr < NREG);
  assign rd_inb = rd_en && (rd_addr < NREG);

  // Per-channel address decode and lock state
  always_comb begin
    wsel = '0;
    rsel = '0;
    lock = '0;
    for (int c = 0; c < N_CH; c++) begin
      wsel[c] = wr_inb && (wr_addr[AW-1:2] == CW'(c));
      rsel[c] = rd_inb && (rd_addr[AW-1:2] == CW'(c));
`ifdef UART_RF_LOCK_EN
      lock[c] = ctrl[c][15];
`else
      lock[c] = 1'b0;
`endif
    end
  end

  // OOB writes, and CTRL/BAUD writes to a locked bank, are rejected
  assign wr_rej = wr_en && (!wr_inb || ((|(wsel & lock)) && !wreg[1]));

  // Register state: commit, shadow load, sticky error, irq
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        ctrl[c] <= '0;
        act[c]  <= BAUD_DEFAULT;
        shd[c]  <= BAUD_DEFAULT;
      end
      busy_q <= '0;
      err    <= '0;
      pend   <= '0;
      ien    <= '0;
      irq_q  <= '0;
      wr_err <= 1'b0;
    end else begin
      busy_q <= uart_busy;
      irq_q  <= err & ien;
      wr_err <= wr_rej;
      for (int c = 0; c < N_CH; c++) begin
        if (wsel[c] && wreg == 2'd0 && !lock[c])
          ctrl[c] <= wr_data;
        if (update_ok[c] && pend[c]) begin
          act[c]  <= shd[c];
          pend[c] <= 1'b0;
        end
        if (wsel[c] && wreg == 2'd1 && !lock[c]) begin
          shd[c]  <= wr_data;
          pend[c] <= 1'b1;
        end
        if (wsel[c] && wreg == 2'd2 && wr_data[1])
          err[c] <= 1'b0;
        if (uart_error[c])
          err[c] <= 1'b1;
        if (wsel[c] && wreg == 2'd3)
          ien[c] <= wr_data[1];
      end
    end
  end

  // Latency-0 read mux with same-address write bypass on CTRL/IRQ_EN
  always_comb begin
    rval = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (rsel[c]) begin
        case (rreg)
          2'd0: rval = (wsel[c] && wreg == 2'd0 && !lock[c]) ? wr_data : ctrl[c];
          2'd1: rval = act[c];
          2'd2: rval = DATA_WIDTH'({pend[c], err[c], busy_q[c]});
          default: rval = DATA_WIDTH'({(wsel[c] && wreg == 2'd3) ? wr_data[1] : ien[c], 1'b0});
        endcase
      end
    end
  end

  generate
    if (READ_LATENCY == 0) begin : g_rl0
      assign rd_data  = rval;
      assign rd_valid = rd_inb;
    end else begin : g_rl1
      // Registered read port
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data  <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_data  <= rval;
          rd_valid <= rd_inb;
        end
      end
    end
  endgenerate

  // UART-facing outputs follow stored registers
  always_comb begin
    uart_enable = '0;
    uart_mode   = '0;
    uart_rate   = '0;
    for (int c = 0; c < N_CH; c++) begin
      uart_enable[c]                      = ctrl[c][0];
      uart_mode[3*c +: 3]                 = ctrl[c][3:1];
      uart_rate[DATA_WIDTH*c +: DATA_WIDTH] = act[c];
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_uart_cfg_regfile_mc.sv
// Bench for uart_cfg_regfile_mc: latency-0 and latency-1 instances share stimulus.
// Directed scenarios then random traffic against a behavioural model.
module tb_uart_cfg_regfile_mc;
  localparam int DW = 16;
  localparam int NC = 2;
  localparam int AW = 4;
`ifdef UART_RF_LOCK_EN
  localparam bit LK = 1'b1;
`else
  localparam bit LK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic wr_en, rd_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic [NC-1:0] uart_busy, uart_error, update_ok;

  logic wr_err0, rd_valid0, wr_err1, rd_valid1;
  logic [DW-1:0] rd_data0, rd_data1;
  logic [NC-1:0] en0, irq0, en1, irq1;
  logic [3*NC-1:0] mode0, mode1;
  logic [DW*NC-1:0] rate0, rate1;

  always #5 clk = ~clk;

  uart_cfg_regfile_mc #(.READ_LATENCY(0)) dut0 (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err0),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .uart_busy(uart_busy), .uart_error(uart_error), .update_ok(update_ok),
    .uart_enable(en0), .uart_mode(mode0), .uart_rate(rate0), .irq(irq0)
  );

  uart_cfg_regfile_mc #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err1),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .uart_busy(uart_busy), .uart_error(uart_error), .update_ok(update_ok),
    .uart_enable(en1), .uart_mode(mode1), .uart_rate(rate1), .irq(irq1)
  );

  // behavioural model of the register banks
  logic [15:0] m_ctrl [NC];
  logic [15:0] m_act  [NC];
  logic [15:0] m_shd  [NC];
  logic [NC-1:0] m_pend, m_err, m_ien, m_busy, m_irq;
  logic m_wrerr, m_rv_q;
  logic [15:0] m_rd_q;

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] exp_read();
    int ch, r;
    logic [15:0] v;
    logic lk;
    if (!rd_en || rd_addr >= 8) return '0;
    ch = int'(rd_addr) / 4;
    r  = int'(rd_addr) % 4;
    lk = LK && m_ctrl[ch][15];
    case (r)
      0: v = (wr_en && wr_addr == rd_addr && !lk) ? wr_data : m_ctrl[ch];
      1: v = m_act[ch];
      2: v = {13'b0, m_pend[ch], m_err[ch], m_busy[ch]};
      default: v = {14'b0, (wr_en && wr_addr == rd_addr) ? wr_data[1] : m_ien[ch], 1'b0};
    endcase
    return {1'b1, v};
  endfunction

  task automatic drive(input logic r_i, input logic we, input logic [3:0] wa,
                       input logic [15:0] wd, input logic re, input logic [3:0] ra,
                       input logic [1:0] ub, input logic [1:0] ue, input logic [1:0] uo);
    @(negedge clk);
    rst = r_i; wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = ra;
    uart_busy = ub; uart_error = ue; update_ok = uo;
    #1;
  endtask

  task automatic check_all();
    logic [16:0] e;
    e = exp_read();
    chk("rd_data0", rd_data0, e[15:0]);
    chk("rd_valid0", rd_valid0, e[16]);
    chk("rd_data1", rd_data1, m_rd_q);
    chk("rd_valid1", rd_valid1, m_rv_q);
    chk("wr_err", wr_err0, m_wrerr);
    chk("wr_err1", wr_err1, m_wrerr);
    chk("irq", irq0, m_irq);
    for (int c = 0; c < NC; c++) begin
      chk("enable", en0[c], m_ctrl[c][0]);
      chk("mode", mode0[3*c +: 3], m_ctrl[c][3:1]);
      chk("rate", rate0[16*c +: 16], m_act[c]);
    end
  endtask

  task automatic step();
    logic [16:0] e;
    int ch, r;
    logic inb, lk;
    e = exp_read();
    if (rst) begin
      for (int c = 0; c < NC; c++) begin
        m_ctrl[c] = '0; m_act[c] = 16'h2580; m_shd[c] = 16'h2580;
      end
      m_pend = '0; m_err = '0; m_ien = '0; m_busy = '0; m_irq = '0;
      m_wrerr = 1'b0; m_rv_q = 1'b0; m_rd_q = '0;
    end else begin
      m_rd_q = e[15:0];
      m_rv_q = e[16];
      inb = wr_en && wr_addr < 8;
      ch  = inb ? int'(wr_addr) / 4 : 0;
      r   = int'(wr_addr) % 4;
      lk  = inb && LK && m_ctrl[ch][15] && r < 2;
      m_wrerr = wr_en && (!inb || lk);
      m_irq = m_err & m_ien;
      m_busy = uart_busy;
      for (int c = 0; c < NC; c++)
        if (update_ok[c] && m_pend[c]) begin
          m_act[c] = m_shd[c];
          m_pend[c] = 1'b0;
        end
      if (inb && !lk)
        case (r)
          0: m_ctrl[ch] = wr_data;
          1: begin m_shd[ch] = wr_data; m_pend[ch] = 1'b1; end
          2: if (wr_data[1]) m_err[ch] = 1'b0;
          default: m_ien[ch] = wr_data[1];
        endcase
      m_err = m_err | uart_error;
    end
    @(posedge clk);
  endtask

  task automatic fin();
    if (!rst) check_all();
    step();
  endtask

  logic r_rst, r_we, r_re;
  logic [3:0] r_wa, r_ra;
  logic [15:0] r_wd;

  initial begin
    // reset for two cycles, then read every register
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); fin();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); fin();
    for (int a = 0; a < 8; a++) begin
      drive(0, 0, 0, 0, 1, 4'(a), 0, 0, 0);
      if (a % 4 == 1) chk("rst_baud", rd_data0, 16'h2580);
      else chk("rst_zero", rd_data0, 16'h0000);
      fin();
    end
    chk("rst_rate", rate0, 32'h2580_2580);

    // shadowed BAUD commit on ch1
    drive(0, 1, 5, 16'h04B0, 0, 0, 0, 0, 0); fin();
    drive(0, 0, 0, 0, 1, 5, 0, 0, 0);
    chk("sh_active", rd_data0, 16'h2580); fin();
    drive(0, 0, 0, 0, 1, 6, 0, 0, 0);
    chk("sh_pend", rd_data0[2], 1'b1); fin();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 2'b10); fin();
    drive(0, 0, 0, 0, 1, 6, 0, 0, 0);
    chk("sh_rate1", rate0[31:16], 16'h04B0);
    chk("sh_rate0", rate0[15:0], 16'h2580);
    chk("sh_pend0", rd_data0[2], 1'b0); fin();

    // error set/clear collision and irq delay
    drive(0, 1, 3, 16'h0002, 0, 0, 0, 2'b01, 0); fin();
    drive(0, 1, 2, 16'h0002, 0, 0, 0, 2'b01, 0); fin();
    drive(0, 1, 2, 16'h0002, 1, 2, 0, 0, 0);
    chk("err_set_wins", rd_data0[1], 1'b1); fin();
    drive(0, 0, 0, 0, 1, 2, 0, 0, 0);
    chk("err_cleared", rd_data0[1], 1'b0);
    chk("irq_lag", irq0[0], 1'b1); fin();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("irq_drop", irq0[0], 1'b0); fin();

    // out of bounds
    drive(0, 1, 8, 16'hFFFF, 0, 0, 0, 0, 0); fin();
    drive(0, 0, 0, 0, 1, 9, 0, 0, 0);
    chk("oob_wr_err", wr_err0, 1'b1);
    chk("oob_rd_data", rd_data0, 16'h0000);
    chk("oob_rd_valid", rd_valid0, 1'b0); fin();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("oob_wr_err_end", wr_err0, 1'b0); fin();

    // read bypass and latency
    drive(0, 1, 0, 16'h000B, 1, 0, 0, 0, 0);
    chk("byp_l0", rd_data0, 16'h000B); fin();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("byp_l1", rd_data1, 16'h000B);
    chk("byp_l1_v", rd_valid1, 1'b1); fin();

`ifdef UART_RF_LOCK_EN
    drive(0, 1, 0, 16'h8001, 0, 0, 0, 0, 0); fin();
    drive(0, 1, 0, 16'h0000, 0, 0, 0, 0, 0); fin();
    drive(0, 1, 1, 16'h1234, 1, 0, 0, 0, 0);
    chk("lock_ctrl", rd_data0, 16'h8001);
    chk("lock_err1", wr_err0, 1'b1); fin();
    drive(0, 0, 0, 0, 1, 6'd2, 0, 0, 0);
    chk("lock_err2", wr_err0, 1'b1);
    chk("lock_pend", rd_data0[2], 1'b0); fin();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); fin();
    drive(0, 1, 0, 16'h0005, 1, 0, 0, 0, 0);
    chk("lock_rst", rd_data0, 16'h0005); fin();
`endif

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 199) == 0);
      r_we  = 1'($urandom);
      r_re  = ($urandom_range(0, 3) != 0);
      r_wa  = 4'($urandom_range(0, 9));
      r_ra  = 4'($urandom_range(0, 9));
      r_wd  = ($urandom_range(0, 3) == 0) ? 16'h0002 : 16'($urandom);
      drive(r_rst, r_we, r_wa, r_wd, r_re, r_ra, 2'($urandom),
            2'($urandom) & 2'($urandom) & 2'($urandom), 2'($urandom));
      fin();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cfg_regfile_mc.md
Name: uart_cfg_regfile_mc

Overview:
Multi-channel successor to the single-UART configuration register file. It holds N_CH identical 4-register banks (CTRL, BAUD, STATUS, IRQ_EN), each driving one UART instance. Each bank has a shadowed BAUD with a commit-pending flag, a sticky W1C error bit, and a per-channel interrupt. It sits between the host bus and the UART channel array, with a single write port and a single read port whose latency is selectable.

Parameters:
DATA_WIDTH, 16, register width; must be >= 16.
N_CH, 2, number of UART channels (1..8).
READ_LATENCY, 0, 0 = combinational read; 1 = registered read.
BAUD_DEFAULT, 16'h2580, reset value of BAUD active and shadow (9600).
AW (localparam), $clog2(4*N_CH)+1, address width; the extra MSB makes out-of-bounds (OOB) addresses encodable.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
wr_en  in  1  write strobe
wr_addr  in  AW  write address; ch = addr/4, reg = addr%4
wr_data  in  DATA_WIDTH  write data
wr_err  out  1  one-cycle pulse, the cycle after a rejected write
rd_en  in  1  read strobe
rd_addr  in  AW  read address
rd_data  out  DATA_WIDTH  read data
rd_valid  out  1  read data valid
uart_busy  in  N_CH  per-channel busy
uart_error  in  N_CH  per-channel error event
update_ok  in  N_CH  per-channel idle; allows BAUD commit
uart_enable  out  N_CH  CTRL[0] of each channel
uart_mode  out  3*N_CH  CTRL[3:1] of each channel; channel c occupies [3c+2:3c]
uart_rate  out  DATA_WIDTH*N_CH  active BAUD of each channel
irq  out  N_CH  STATUS.error & IRQ_EN[1], registered

Behaviour:
- Register map per channel, base = 4*ch:
  - 0 CTRL: fully RW.
  - 1 BAUD: writes go to shadow; reads return the active value.
  - 2 STATUS: [0] busy RO, mirrors uart_busy registered; [1] error sticky, W1C; [2] pending RO; other bits reserved, read 0.
  - 3 IRQ_EN: [1] RW; all other bits reserved, read 0.
- Reset, applied on the clk edge while rst=1:
  - CTRL=0, IRQ_EN=0, STATUS=0.
  - BAUD active = BAUD shadow = BAUD_DEFAULT.
  - wr_err=0, rd_data=0, rd_valid=0, irq=0.
  - Any pending commit is discarded.
- BAUD commit:
  - A write to BAUD loads shadow and sets pending=1.
  - On any cycle with update_ok[ch]=1 and pending=1: active<=shadow, pending<=0.
  - A write in the same cycle as a commit: the commit takes the old shadow, the new data loads shadow, and pending stays 1.
- Error bit:
  - uart_error[ch]=1 sets the error bit.
  - Writing 1 to STATUS[1] clears it.
  - Set and clear in the same cycle: set wins, bit stays 1.
  - Writing 0 to STATUS[1] has no effect.
- Rejected writes:
  - OOB writes (addr >= 4*N_CH) change no state.
  - Writes to RO or reserved bits have no effect on stored state and are not treated as rejected.
  - wr_err pulses one cycle after an OOB write (and after a locked write, see the Optional Feature).
- Read path:
  - READ_LATENCY=0: rd_valid = rd_en & in-bounds, combinational.
  - READ_LATENCY=0, rd_data: same-cycle write to the same CTRL or IRQ_EN address returns the new data (bypass). BAUD returns active, never shadow. STATUS returns stored state.
  - READ_LATENCY=1: rd_data/rd_valid register the latency-0 values one cycle later.
  - rd_en=0 or OOB: rd_valid=0 and rd_data=0.
  - Back-to-back reads are supported every cycle.
- Outputs:
  - uart_enable, uart_mode and uart_rate follow the stored registers combinationally.
  - irq updates one cycle after its source changes.
- All channels are independent; no cross-channel interaction.

Optional Feature:
UART_RF_LOCK_EN defined:
- CTRL[15] becomes LOCK, set-only: writing 1 sets it; only rst clears it.
- While LOCK=1, writes to that channel's CTRL and BAUD are ignored and cause a wr_err pulse.
- STATUS W1C and IRQ_EN writes remain allowed.
- A commit of an already-pending shadow still happens on update_ok.

UART_RF_LOCK_EN undefined:
- CTRL[15] is a plain RW bit.
- wr_err pulses only for OOB writes.

Test Plan:
- Reset check: assert rst for 2 cycles -> all channels read CTRL=0, BAUD=0x2580, STATUS=0; uart_rate = 0x2580 per channel; irq=0; wr_err=0.
- Shadow commit: write ch1 BAUD=0x04B0 with update_ok[1]=0 -> read returns 0x2580 and STATUS[2]=1. Raise update_ok[1] -> uart_rate ch1 = 0x04B0 next cycle, pending=0; ch0 unchanged.
- Error collision: pulse uart_error[0], then write STATUS ch0 = 0x0002 in the same cycle as a new uart_error[0] -> error stays 1. Clear in a later cycle -> STATUS[1]=0; with IRQ_EN[1]=1, irq[0] follows one cycle late.
- Out of bounds: N_CH=2, write addr 8 data 0xFFFF -> no register changes, wr_err pulse next cycle. Read addr 9 -> rd_data=0, rd_valid=0.
- Read latency: READ_LATENCY=0, write CTRL ch0=0x000B while reading addr 0 -> rd_data=0x000B same cycle. READ_LATENCY=1 -> 0x000B with rd_valid=1 one cycle later.
- Lock (macro on): write CTRL ch0=0x8001, then CTRL=0x0000 and BAUD=0x1234 -> CTRL stays 0x8001, shadow unchanged, two wr_err pulses; rst clears LOCK.
